// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt controller: synchronizes, latches and masks peripheral
// requests, then hands one at a time to the CPU through a fixed-priority arbiter.
module irq_arbiter #(
    parameter int         N_SRC = 4,
    parameter int         ID_W  = 3,
    parameter logic [7:0] BASE  = 8'h40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq_i,
    input  logic             kernel_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             irq_out_o,
    output logic             irq_active_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    localparam logic [5:0] OFF_PEND  = BASE[7:2];
    localparam logic [5:0] OFF_MASK  = BASE[7:2] + 6'd1;
    localparam logic [5:0] OFF_EDGE  = BASE[7:2] + 6'd2;
    localparam logic [5:0] OFF_CAUSE = BASE[7:2] + 6'd3;
    localparam logic [5:0] OFF_EOI   = BASE[7:2] + 6'd4;

    logic [N_SRC-1:0] s1_q, s2_q, s3_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] edge_q;
    logic             cause_valid_q;
    logic [ID_W-1:0]  cause_id_q;
    logic             kernel_q;
    state_t           state_q;
    logic             irq_out_q;
    logic             irq_active_q;

    logic [N_SRC-1:0] req;
    logic             has_req;
    logic [ID_W-1:0]  win_id;
    logic             accept;
    logic             kernel_fall;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] acc_clr;
    logic [5:0]       word;
    logic             wr_pend, wr_mask, wr_edge, wr_eoi;
    logic             unused_bits;

    assign word    = addr_i[7:2];
    assign wr_pend = wr_i && (word == OFF_PEND);
    assign wr_mask = wr_i && (word == OFF_MASK);
    assign wr_edge = wr_i && (word == OFF_EDGE);
    assign wr_eoi  = wr_i && (word == OFF_EOI);

    assign unused_bits = ^{addr_i[31:8], addr_i[1:0], wdata_i[31:N_SRC]};

    // Two flops for metastability, a third to spot rising edges of the clean signal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= src_irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign req         = pend_q & mask_q;
    assign has_req     = |req;
    assign accept      = (state_q == REQ) && has_req && kernel_i && !kernel_q;
    assign kernel_fall = kernel_q && !kernel_i;

    // Lowest index wins, so scan downwards and let later hits overwrite.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        acc_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (accept && (win_id == ID_W'(i))) begin
                acc_clr[i] = 1'b1;
            end
        end
    end

    assign edge_set = s2_q & ~s3_q;
    assign w1c_clr  = wr_pend ? wdata_i[N_SRC-1:0] : '0;

    // A fresh edge in the same cycle as a clear keeps the bit set.
    assign pend_d = (edge_q & (edge_set | (pend_q & ~(w1c_clr | acc_clr))))
                  | (~edge_q & s2_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= wdata_i[N_SRC-1:0];
            end
            if (wr_edge) begin
                edge_q <= wdata_i[N_SRC-1:0];
            end
        end
    end

    // Outputs are written alongside each transition so they always match the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            irq_out_q     <= 1'b0;
            irq_active_q  <= 1'b0;
            cause_valid_q <= 1'b0;
            cause_id_q    <= '0;
            kernel_q      <= 1'b0;
        end else begin
            kernel_q <= kernel_i;
            case (state_q)
                IDLE: begin
                    if (has_req && !kernel_i) begin
                        state_q   <= REQ;
                        irq_out_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (!has_req) begin
                        state_q   <= IDLE;
                        irq_out_q <= 1'b0;
                    end else if (accept) begin
                        state_q       <= SERVICE;
                        irq_out_q     <= 1'b0;
                        irq_active_q  <= 1'b1;
                        cause_valid_q <= 1'b1;
                        cause_id_q    <= win_id;
                    end
                end
                SERVICE: begin
                    if (wr_eoi || kernel_fall) begin
                        state_q       <= IDLE;
                        irq_active_q  <= 1'b0;
                        cause_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    irq_out_q    <= 1'b0;
                    irq_active_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        if (rd_i) begin
            if (word == OFF_PEND) begin
                rdata_o = {{(32 - N_SRC){1'b0}}, pend_q};
            end else if (word == OFF_MASK) begin
                rdata_o = {{(32 - N_SRC){1'b0}}, mask_q};
            end else if (word == OFF_EDGE) begin
                rdata_o = {{(32 - N_SRC){1'b0}}, edge_q};
            end else if (word == OFF_CAUSE) begin
                rdata_o = {cause_valid_q, {(31 - ID_W){1'b0}}, cause_id_q};
            end
        end
    end

    assign irq_out_o    = irq_out_q;
    assign irq_active_o = irq_active_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scenario bench for irq_arbiter: expectations are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_irq_arbiter;

    localparam logic [31:0] A_PEND  = 32'h4000_0040;
    localparam logic [31:0] A_MASK  = 32'h4000_0044;
    localparam logic [31:0] A_EDGE  = 32'h4000_0048;
    localparam logic [31:0] A_CAUSE = 32'h4000_004C;
    localparam logic [31:0] A_EOI   = 32'h4000_0050;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  srcIrq = '0;
    logic        kernel = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irqOut;
    logic        irqActive;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expQ[$];
    logic [31:0] got;
    logic [31:0] expVal;
    bit          ok;

    irq_arbiter #(.N_SRC(4), .ID_W(3), .BASE(8'h40)) dut (
        .clk         (clk),
        .reset       (reset),
        .src_irq_i   (srcIrq),
        .kernel_i    (kernel),
        .rd_i        (rd),
        .wr_i        (wr),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .irq_out_o   (irqOut),
        .irq_active_o(irqActive)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
    endtask

    task automatic doReset();
        reset  = 1'b0;
        srcIrq = '0;
        kernel = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        tick(2);
        reset  = 1'b1;
        tick(1);
    endtask

    task automatic waitIrq(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (irqOut === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        logic [31:0] regs[5];
        regs = '{A_PEND, A_MASK, A_EDGE, A_CAUSE, A_EOI};
        doReset();
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(32'h0);
            busRead(regs[i], got);
            expVal = expQ.pop_front();
            total++;
            if (got !== expVal) begin
                bad++;
                $display("[TB] FAIL reset_reg%0d got=%h exp=%h", i, got, expVal);
            end
        end
        expQ.push_back(32'h0);
        got = {30'b0, irqOut, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h exp=%h", got, expVal);
        end
    endtask

    task automatic test_edge_service();
        doReset();
        busWrite(A_MASK, 32'h2);
        busWrite(A_EDGE, 32'h2);
        srcIrq = 4'b0010;
        tick(1);
        srcIrq = 4'b0000;
        expQ.push_back(32'h0);
        tick(2);
        got = {31'b0, irqOut};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL edge_latency_early got=%h exp=%h", got, expVal);
        end
        expQ.push_back(32'h1);
        tick(1);
        got = {31'b0, irqOut};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL edge_latency got=%h exp=%h", got, expVal);
        end
        kernel = 1'b1;
        expQ.push_back(32'h0);
        busRead(A_CAUSE, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL cause_pre_accept got=%h exp=%h", got, expVal);
        end
        expQ.push_back(32'h1);
        expQ.push_back(32'h8000_0001);
        expQ.push_back(32'h0);
        tick(1);
        got = {30'b0, irqOut, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL accept_outputs got=%h exp=%h", got, expVal);
        end
        busRead(A_CAUSE, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL accept_cause got=%h exp=%h", got, expVal);
        end
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL accept_pend_clear got=%h exp=%h", got, expVal);
        end
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        busWrite(A_EOI, 32'h0);
        got = {31'b0, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL eoi_active got=%h exp=%h", got, expVal);
        end
        busRead(A_CAUSE, got);
        got = got & 32'h8000_0000;
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL eoi_cause_valid got=%h exp=%h", got, expVal);
        end
        kernel = 1'b0;
        tick(1);
    endtask

    task automatic test_priority();
        doReset();
        busWrite(A_MASK, 32'hF);
        srcIrq = 4'b1001;
        expQ.push_back(32'h1);
        waitIrq(ok);
        got = {31'b0, ok};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL prio_irq_timeout got=%h exp=%h", got, expVal);
        end
        kernel = 1'b1;
        expQ.push_back(32'h8000_0000);
        tick(1);
        busRead(A_CAUSE, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL prio_first_cause got=%h exp=%h", got, expVal);
        end
        srcIrq = 4'b1000;
        tick(3);
        busWrite(A_EOI, 32'h0);
        kernel = 1'b0;
        expQ.push_back(32'h1);
        waitIrq(ok);
        got = {31'b0, ok};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL prio_second_irq got=%h exp=%h", got, expVal);
        end
        kernel = 1'b1;
        expQ.push_back(32'h8000_0003);
        tick(1);
        busRead(A_CAUSE, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL prio_second_cause got=%h exp=%h", got, expVal);
        end
        srcIrq = 4'b0000;
        busWrite(A_EOI, 32'h0);
        kernel = 1'b0;
        tick(1);
    endtask

    task automatic test_pending_in_service();
        doReset();
        busWrite(A_MASK, 32'hF);
        busWrite(A_EDGE, 32'hF);
        srcIrq = 4'b0001;
        tick(1);
        srcIrq = 4'b0000;
        waitIrq(ok);
        kernel = 1'b1;
        expQ.push_back(32'h1);
        tick(1);
        got = {31'b0, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL svc_enter got=%h exp=%h", got, expVal);
        end
        srcIrq = 4'b0100;
        tick(1);
        srcIrq = 4'b0000;
        expQ.push_back(32'h0);
        expQ.push_back(32'h4);
        tick(5);
        got = {31'b0, irqOut};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL svc_hold_irq got=%h exp=%h", got, expVal);
        end
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL svc_pend_kept got=%h exp=%h", got, expVal);
        end
        kernel = 1'b0;
        expQ.push_back(32'h0);
        tick(1);
        got = {30'b0, irqOut, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL implicit_eoi got=%h exp=%h", got, expVal);
        end
        expQ.push_back(32'h1);
        expQ.push_back(32'h4);
        tick(1);
        got = {31'b0, irqOut};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL rerequest_irq got=%h exp=%h", got, expVal);
        end
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL rerequest_pend got=%h exp=%h", got, expVal);
        end
        kernel = 1'b1;
        tick(1);
        busWrite(A_EOI, 32'h0);
        kernel = 1'b0;
        tick(1);
    endtask

    task automatic test_mask_in_req();
        doReset();
        busWrite(A_MASK, 32'hF);
        srcIrq = 4'b0010;
        waitIrq(ok);
        busWrite(A_MASK, 32'h0);
        expQ.push_back(32'h0);
        tick(1);
        got = {31'b0, irqOut};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL mask_drop_irq got=%h exp=%h", got, expVal);
        end
        kernel = 1'b1;
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        tick(2);
        busRead(A_CAUSE, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL mask_no_accept_cause got=%h exp=%h", got, expVal);
        end
        got = {31'b0, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL mask_no_accept_active got=%h exp=%h", got, expVal);
        end
        kernel = 1'b0;
        srcIrq = 4'b0000;
        tick(1);
    endtask

    task automatic test_w1c();
        doReset();
        busWrite(A_EDGE, 32'h4);
        srcIrq = 4'b0100;
        tick(1);
        srcIrq = 4'b0000;
        tick(3);
        expQ.push_back(32'h4);
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL w1c_pend_set got=%h exp=%h", got, expVal);
        end
        busWrite(A_PEND, 32'h4);
        expQ.push_back(32'h0);
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL w1c_clear got=%h exp=%h", got, expVal);
        end
        srcIrq = 4'b0100;
        tick(1);
        srcIrq = 4'b0000;
        tick(1);
        busWrite(A_PEND, 32'h4);
        expQ.push_back(32'h4);
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL w1c_set_wins got=%h exp=%h", got, expVal);
        end
        busWrite(A_EDGE, 32'h0);
        srcIrq = 4'b0100;
        tick(3);
        busWrite(A_PEND, 32'h4);
        expQ.push_back(32'h4);
        busRead(A_PEND, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL w1c_level_ignored got=%h exp=%h", got, expVal);
        end
        srcIrq = 4'b0000;
        tick(1);
    endtask

    task automatic test_reset_in_service();
        doReset();
        busWrite(A_MASK, 32'hF);
        srcIrq = 4'b0001;
        waitIrq(ok);
        kernel = 1'b1;
        tick(1);
        expQ.push_back(32'h1);
        got = {31'b0, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL rst_svc_enter got=%h exp=%h", got, expVal);
        end
        reset = 1'b0;
        #1;
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h0);
        got = {30'b0, irqOut, irqActive};
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL rst_async_outputs got=%h exp=%h", got, expVal);
        end
        busRead(A_CAUSE, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL rst_async_cause got=%h exp=%h", got, expVal);
        end
        busRead(A_MASK, got);
        expVal = expQ.pop_front();
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL rst_async_mask got=%h exp=%h", got, expVal);
        end
        srcIrq = 4'b0000;
        kernel = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        $display("[TB] starting irq_arbiter scenarios");
        test_reset();
        test_edge_service();
        test_priority();
        test_pending_in_service();
        test_mask_in_req();
        test_w1c();
        test_reset_in_service();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
